// File: rtl/core_div_pkg.sv
// Shared definitions for the divide path: op encodings and the iterative divider state.
package core_div_pkg;

  localparam logic [1:0] DIV  = 2'b00;
  localparam logic [1:0] DIVU = 2'b01;
  localparam logic [1:0] REM  = 2'b10;
  localparam logic [1:0] REMU = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // DIV and REM are the signed encodings (bit 0 clear).
  function automatic logic is_signed_op(input logic [1:0] control);
    return ~control[0];
  endfunction

endpackage

// File: rtl/core_div_abs.sv
// Operand conditioning: optional W-width zero extension, absolute value and sign extraction.
module core_div_abs #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] value,
  input  logic            is_signed,
  input  logic            isword,
  output logic [XLEN-1:0] mag,
  output logic            dsign,
  output logic            wsign
);

  localparam int HALF = XLEN / 2;

  logic [HALF-1:0] low_neg;
  logic [XLEN-1:0] full_neg;

  assign low_neg  = -value[HALF-1:0];
  assign full_neg = -value;
  assign dsign    = is_signed & value[XLEN-1];
  assign wsign    = is_signed & value[HALF-1];

  always_comb begin
    mag = value;
    if (isword) begin
      mag = {{HALF{1'b0}}, (wsign ? low_neg : value[HALF-1:0])};
    end else if (dsign) begin
      mag = full_neg;
    end
  end

endmodule

// File: rtl/core_div_iter.sv
// Radix-2 restoring divider producing unsigned quotient/remainder magnitudes plus the
// sign, control and word information the result-formatting stage needs.
module core_div_iter
  import core_div_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_div_iter_valid,
  output logic            o_div_iter_ready,
  input  logic [XLEN-1:0] i_div_iter_srcA,
  input  logic [XLEN-1:0] i_div_iter_srcB,
  input  logic [1:0]      i_div_iter_control,
  input  logic            i_div_iter_isword,
  input  logic            i_div_iter_flush,
  output logic            o_div_iter_valid,
  input  logic            i_div_iter_ready,
  output logic [XLEN-1:0] o_div_iter_quotient,
  output logic [XLEN-1:0] o_div_iter_remainder,
  output logic            o_div_iter_srcA_Dsign,
  output logic            o_div_iter_srcB_Dsign,
  output logic            o_div_iter_srcA_Wsign,
  output logic            o_div_iter_srcB_Wsign,
  output logic [1:0]      o_div_iter_control,
  output logic            o_div_iter_isword
);

  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN) + 1;

  div_state_e state_reg, state_next;

  logic [XLEN-1:0] rem_reg, quo_reg, div_reg;
  logic [CW-1:0]   cnt_reg;
  logic [1:0]      control_reg;
  logic            isword_reg;
  logic            a_dsign_reg, b_dsign_reg, a_wsign_reg, b_wsign_reg;

  logic [1:0][XLEN-1:0] src_raw, src_mag;
  logic [1:0]           src_dsign, src_wsign;
  logic                 op_signed, div_zero, accept, last_iter;

  logic [XLEN:0]   rem_shifted, trial;
  logic [XLEN-1:0] rem_next, quo_next;

  assign src_raw[0] = i_div_iter_srcA;
  assign src_raw[1] = i_div_iter_srcB;
  assign op_signed  = is_signed_op(i_div_iter_control);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_abs
      core_div_abs #(.XLEN(XLEN)) u_abs (
        .value     (src_raw[gi]),
        .is_signed (op_signed),
        .isword    (i_div_iter_isword),
        .mag       (src_mag[gi]),
        .dsign     (src_dsign[gi]),
        .wsign     (src_wsign[gi])
      );
    end
  endgenerate

  assign div_zero  = (src_mag[1] == '0);
  assign accept    = i_div_iter_valid & o_div_iter_ready & ~i_div_iter_flush;
  assign last_iter = (cnt_reg == CW'(1));

  // Remainder is always below the divisor, so one extra bit holds the trial borrow.
  assign rem_shifted = {rem_reg, quo_reg[XLEN-1]};
  assign trial       = rem_shifted - {1'b0, div_reg};
  assign rem_next    = trial[XLEN] ? rem_shifted[XLEN-1:0] : trial[XLEN-1:0];
  assign quo_next    = {quo_reg[XLEN-2:0], ~trial[XLEN]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (i_div_iter_flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (accept) state_next = div_zero ? DONE : CALC;
        CALC:    if (last_iter) state_next = DONE;
        DONE:    if (i_div_iter_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    o_div_iter_ready = (state_reg == IDLE);
    o_div_iter_valid = (state_reg == DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rem_reg     <= '0;
      quo_reg     <= '0;
      div_reg     <= '0;
      cnt_reg     <= '0;
      control_reg <= '0;
      isword_reg  <= 1'b0;
      a_dsign_reg <= 1'b0;
      b_dsign_reg <= 1'b0;
      a_wsign_reg <= 1'b0;
      b_wsign_reg <= 1'b0;
    end else if (accept) begin
      control_reg <= i_div_iter_control;
      isword_reg  <= i_div_iter_isword;
      a_dsign_reg <= src_dsign[0];
      a_wsign_reg <= src_wsign[0];
      // Mirroring the dividend sign on x/0 cancels the downstream negation of all-ones.
      b_dsign_reg <= div_zero ? src_dsign[0] : src_dsign[1];
      b_wsign_reg <= div_zero ? src_wsign[0] : src_wsign[1];
      div_reg     <= src_mag[1];
      cnt_reg     <= i_div_iter_isword ? CW'(HALF) : CW'(XLEN);
      if (div_zero) begin
        quo_reg <= '1;
        rem_reg <= src_mag[0];
      end else begin
        rem_reg <= '0;
        // W dividends start in the upper half so the MSB-first shift sees them first.
        quo_reg <= i_div_iter_isword ? {src_mag[0][HALF-1:0], {HALF{1'b0}}} : src_mag[0];
      end
    end else if (state_reg == CALC && !i_div_iter_flush) begin
      rem_reg <= rem_next;
      quo_reg <= quo_next;
      cnt_reg <= cnt_reg - CW'(1);
    end
  end

  assign o_div_iter_quotient   = quo_reg;
  assign o_div_iter_remainder  = rem_reg;
  assign o_div_iter_srcA_Dsign = a_dsign_reg;
  assign o_div_iter_srcB_Dsign = b_dsign_reg;
  assign o_div_iter_srcA_Wsign = a_wsign_reg;
  assign o_div_iter_srcB_Wsign = b_wsign_reg;
  assign o_div_iter_control    = control_reg;
  assign o_div_iter_isword     = isword_reg;

endmodule
